// File: rtl/rs232_ep_arb.sv
// Round-robin arbiter copying one of two capture buffers into a USB IN endpoint.
// Define RS232_ARB_HDR_EN to prefix each transfer with a {channel, sequence} header byte.
module rs232_ep_arb #(
    parameter int          PAYLOAD_LEN = 256,
    parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [8:0] buf_in_addr,
    output logic [7:0] buf_in_data,
    output logic       buf_in_wren,
    input  logic       buf_in_ready,
    output logic       buf_in_commit,
    output logic [9:0] buf_in_commit_len,
    input  logic       buf_in_commit_ack,
    output logic       timeout_err
);

`ifdef RS232_ARB_HDR_EN
    localparam int OFFSET = 1;
`else
    localparam int OFFSET = 0;
`endif

    localparam logic [8:0]  LAST_IDX   = 9'(PAYLOAD_LEN - 1);
    localparam logic [8:0]  ADDR_OFF   = 9'(OFFSET);
    localparam logic [9:0]  COMMIT_LEN = 10'(PAYLOAD_LEN + OFFSET);
    localparam logic [15:0] TO_LAST    = ACK_TIMEOUT - 16'd1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARB, ST_WAIT_RDY, ST_RD, ST_WR, ST_COMMIT, ST_WAIT_ACK, ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        ready_s1, ready_s2;
    logic        ack_s1, ack_s2, ack_s3;
    logic        ack_rise;
    logic [1:0]  grant_q;
    logic [1:0]  arb_pick;
    logic        last_ch;
    logic [8:0]  byte_cnt;
    logic [15:0] to_cnt;
    logic        hdr_pending;
    logic [7:0]  hdr_byte;

    // NOTE: flops take <= so every register samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_s1 <= 1'b0;
            ready_s2 <= 1'b0;
            ack_s1   <= 1'b0;
            ack_s2   <= 1'b0;
            ack_s3   <= 1'b0;
        end else begin
            ready_s1 <= buf_in_ready;
            ready_s2 <= ready_s1;
            ack_s1   <= buf_in_commit_ack;
            ack_s2   <= ack_s1;
            ack_s3   <= ack_s2;
        end
    end

    assign ack_rise = ack_s2 & ~ack_s3;

    // On a tie, serve the channel that was not served last.
    always_comb begin
        arb_pick = 2'b00;
        case (req)
            2'b01:   arb_pick = 2'b01;
            2'b10:   arb_pick = 2'b10;
            2'b11:   arb_pick = last_ch ? 2'b01 : 2'b10;
            default: arb_pick = 2'b00;
        endcase
    end

`ifdef RS232_ARB_HDR_EN
    logic [6:0] seq0_q, seq1_q;

    assign hdr_byte = {grant_q[1], grant_q[1] ? seq1_q : seq0_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_pending <= 1'b0;
            seq0_q      <= 7'd0;
            seq1_q      <= 7'd0;
        end else begin
            case (state_q)
                ST_IDLE: hdr_pending <= 1'b1;
                ST_WR:   hdr_pending <= 1'b0;
                ST_DONE: begin
                    if (grant_q[1]) seq1_q <= seq1_q + 7'd1;
                    else            seq0_q <= seq0_q + 7'd1;
                end
                default: ;
            endcase
        end
    end
`else
    assign hdr_pending = 1'b0;
    assign hdr_byte    = 8'h00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output and next-state value is defaulted first so no latch is inferred.
    always_comb begin
        state_d           = state_q;
        done              = 2'b00;
        buf_in_wren       = 1'b0;
        buf_in_addr       = 9'd0;
        buf_in_data       = 8'h00;
        buf_in_commit     = 1'b0;
        buf_in_commit_len = 10'd0;
        case (state_q)
            ST_IDLE:     if (req != 2'b00) state_d = ST_ARB;
            ST_ARB:      state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: if (ready_s2) state_d = ST_RD;
            ST_RD:       state_d = ST_WR;
            ST_WR: begin
                buf_in_wren = 1'b1;
                if (hdr_pending) begin
                    buf_in_data = hdr_byte;
                    state_d     = ST_RD;
                end else begin
                    buf_in_addr = byte_cnt + ADDR_OFF;
                    buf_in_data = rd_data;
                    state_d     = (byte_cnt == LAST_IDX) ? ST_COMMIT : ST_RD;
                end
            end
            ST_COMMIT: begin
                buf_in_commit     = 1'b1;
                buf_in_commit_len = COMMIT_LEN;
                state_d           = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: if (ack_rise || to_cnt == TO_LAST) state_d = ST_DONE;
            ST_DONE: begin
                done    = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q     <= 2'b00;
            last_ch     <= 1'b1;
            byte_cnt    <= 9'd0;
            to_cnt      <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    grant_q  <= arb_pick;
                    byte_cnt <= 9'd0;
                end
                ST_WR: begin
                    if (!hdr_pending && byte_cnt != LAST_IDX) byte_cnt <= byte_cnt + 9'd1;
                end
                ST_COMMIT: to_cnt <= 16'd0;
                ST_WAIT_ACK: begin
                    if (!ack_rise) begin
                        if (to_cnt == TO_LAST) timeout_err <= 1'b1;
                        else                   to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    grant_q  <= 2'b00;
                    last_ch  <= grant_q[1];
                    byte_cnt <= 9'd0;
                end
                default: ;
            endcase
        end
    end

    assign grant   = grant_q;
    assign rd_addr = byte_cnt;

endmodule

// File: tb/tb_rs232_ep_arb.sv
// Directed self-checking bench for rs232_ep_arb (PAYLOAD_LEN=4, ACK_TIMEOUT=100).
module tb_rs232_ep_arb;

    localparam int          PL = 4;
    localparam logic [15:0] TO = 16'd100;
`ifdef RS232_ARB_HDR_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] done;
    logic [8:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       buf_in_ready;
    logic       buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic       buf_in_commit_ack;
    logic       timeout_err;

    int         tests = 0;
    int         fails = 0;
    logic [6:0] seq_exp [2];

    rs232_ep_arb #(.PAYLOAD_LEN(PL), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Capture buffer: byte at address a is a + 0x10, returned one cycle after the address.
    always @(posedge clk) rd_data <= rd_addr[7:0] + 8'h10;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":grant"},       32'(grant), 32'd0);
        check({tag, ":done"},        32'(done), 32'd0);
        check({tag, ":rd_addr"},     32'(rd_addr), 32'd0);
        check({tag, ":addr"},        32'(buf_in_addr), 32'd0);
        check({tag, ":data"},        32'(buf_in_data), 32'd0);
        check({tag, ":wren"},        32'(buf_in_wren), 32'd0);
        check({tag, ":commit"},      32'(buf_in_commit), 32'd0);
        check({tag, ":commit_len"},  32'(buf_in_commit_len), 32'd0);
        check({tag, ":timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // Follows one transfer to its done pulse, acknowledging the commit if asked.
    task automatic xfer(input string tag, input logic [1:0] exp_g, input bit send_ack,
                        input bit drop_req, output int commit_cyc, output int done_cyc,
                        output int first_wren_cyc);
        int         ch;
        logic [8:0] waddr [$];
        logic [7:0] wdata [$];
        int         commits;
        logic [9:0] clen;
        bit         grant_ok;
        bit         got_done;
        int         ack_dly;
        logic [1:0] done_v;
        logic [1:0] grant_at_done;
        logic [7:0] e;
        ch = exp_g[1] ? 1 : 0;
        commits = 0; clen = 10'd0; grant_ok = 1'b1; got_done = 1'b0; ack_dly = -1;
        done_v = 2'b00; grant_at_done = 2'b00;
        commit_cyc = -1; done_cyc = -1; first_wren_cyc = -1;
        for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
            @(negedge clk);
            if (grant !== 2'b00 && grant !== exp_g) grant_ok = 1'b0;
            if (drop_req && grant === exp_g) req = 2'b00;
            if (buf_in_wren === 1'b1) begin
                if (first_wren_cyc < 0) first_wren_cyc = cyc;
                waddr.push_back(buf_in_addr);
                wdata.push_back(buf_in_data);
            end
            if (buf_in_commit === 1'b1) begin
                commits++;
                clen = buf_in_commit_len;
                commit_cyc = cyc;
                if (send_ack) ack_dly = 3;
            end
            if (ack_dly == 0) buf_in_commit_ack = 1'b1;
            if (ack_dly > 0) ack_dly--;
            if (done !== 2'b00) begin
                got_done = 1'b1;
                done_v = done;
                done_cyc = cyc;
                grant_at_done = grant;
            end
        end
        buf_in_commit_ack = 1'b0;
        check({tag, ":got_done"},      32'(got_done), 32'd1);
        check({tag, ":done"},          32'(done_v), 32'(exp_g));
        check({tag, ":grant_stable"},  32'(grant_ok), 32'd1);
        check({tag, ":grant_at_done"}, 32'(grant_at_done), 32'(exp_g));
        check({tag, ":commits"},       32'(commits), 32'd1);
        check({tag, ":commit_len"},    32'(clen), 32'(PL + OFF));
        check({tag, ":wr_count"},      32'(waddr.size()), 32'(PL + OFF));
        for (int i = 0; i < waddr.size() && i < PL + OFF; i++) begin
            if (OFF == 1 && i == 0) e = {exp_g[1], seq_exp[ch]};
            else                    e = 8'h10 + 8'(i - OFF);
            check($sformatf("%s:wr_addr%0d", tag, i), 32'(waddr[i]), 32'(i));
            check($sformatf("%s:wr_data%0d", tag, i), 32'(wdata[i]), 32'(e));
        end
        seq_exp[ch] = seq_exp[ch] + 7'd1;
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":grant_cleared"},  32'(grant), 32'd0);
    endtask

    initial begin
        int  c_cyc, d_cyc, w_cyc;
        bit  seen;
        bit  bad;
        reset = 1'b1; req = 2'b00; buf_in_ready = 1'b0; buf_in_commit_ack = 1'b0;
        seq_exp[0] = 7'd0; seq_exp[1] = 7'd0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("post_reset_idle");

        // Single request, dropped once granted; bytes 10..13 expected.
        buf_in_ready = 1'b1;
        req = 2'b01;
        xfer("t1", 2'b01, 1'b1, 1'b1, c_cyc, d_cyc, w_cyc);
        check("t1:timeout_err", 32'(timeout_err), 32'd0);

        // Ready held low for 20 cycles after the grant.
        buf_in_ready = 1'b0;
        repeat (3) @(negedge clk);
        req = 2'b10;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (buf_in_wren !== 1'b0) bad = 1'b1;
        end
        check("rdy:no_wren_while_low", 32'(bad), 32'd0);
        check("rdy:grant_held", 32'(grant), 32'(2'b10));
        buf_in_ready = 1'b1;
        xfer("t2", 2'b10, 1'b1, 1'b1, c_cyc, d_cyc, w_cyc);
        check("rdy:first_wren_cycle", 32'(w_cyc), 32'd4);

        // Reset while byte 2 is being written.
        req = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (buf_in_wren === 1'b1 && buf_in_addr === 9'(OFF + 2)) seen = 1'b1;
        end
        check("midrst:reached_byte2", 32'(seen), 32'd1);
        reset = 1'b1;
        req = 2'b00;
        #1;
        check_zero("midrst");
        seq_exp[0] = 7'd0; seq_exp[1] = 7'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (buf_in_commit !== 1'b0 || done !== 2'b00) bad = 1'b1;
        end
        check("midrst:no_commit_no_done", 32'(bad), 32'd0);

        // Both channels held: grants alternate 01, 10, 01 after reset.
        req = 2'b11;
        xfer("rr1", 2'b01, 1'b1, 1'b0, c_cyc, d_cyc, w_cyc);
        xfer("rr2", 2'b10, 1'b1, 1'b0, c_cyc, d_cyc, w_cyc);
        xfer("rr3", 2'b01, 1'b1, 1'b0, c_cyc, d_cyc, w_cyc);
        req = 2'b00;

        // Stray ack pulse while idle, then a transfer with no ack at all.
        repeat (2) @(negedge clk);
        buf_in_commit_ack = 1'b1;
        repeat (4) @(negedge clk);
        buf_in_commit_ack = 1'b0;
        repeat (4) @(negedge clk);
        req = 2'b01;
        xfer("to", 2'b01, 1'b0, 1'b1, c_cyc, d_cyc, w_cyc);
        check("to:done_latency", 32'(d_cyc - c_cyc), 32'd101);
        check("to:timeout_err_set", 32'(timeout_err), 32'd1);

        req = 2'b10;
        xfer("after_to", 2'b10, 1'b1, 1'b1, c_cyc, d_cyc, w_cyc);
        check("after_to:timeout_err_sticky", 32'(timeout_err), 32'd1);

        reset = 1'b1;
        @(negedge clk);
        check_zero("final_reset");
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
